// File: rtl/sbuf_pkg.sv
// Shared-buffer arbitration helpers: round-robin pick, one-hot to index, lock state type.
// Latency: purely combinational functions, no state.
// Backpressure: not applicable; callers gate the pick with their own load condition.
//
// Contents:
//   lk_state_t  packet-lock state (LK_IDLE / LK_LOCKED)
//   rr_pick_t   {found, idx} result of a round-robin scan
//   rr_pick     first set bit of req scanning ptr, ptr+1, ... wrapping at n
//   onehot2idx  index of the set bit of an at-most-one-hot vector (0 when empty)
package sbuf_pkg;

  // Upper bound on requester count handled by the helper functions.
  localparam int unsigned MAX_N  = 32;
  localparam int unsigned MAX_IW = 5;

  typedef enum logic [0:0] {
    LK_IDLE   = 1'b0,
    LK_LOCKED = 1'b1
  } lk_state_t;

  typedef struct packed {
    logic              found;
    logic [MAX_IW-1:0] idx;
  } rr_pick_t;

  // Scan order is ptr, ptr+1, ..., n-1, 0, ..., ptr-1; ptr must be below n.
  function automatic rr_pick_t rr_pick(input logic [MAX_N-1:0]  req,
                                       input logic [MAX_IW-1:0] ptr,
                                       input int unsigned       n);
    rr_pick_t    res;
    int unsigned idx;
    res = '0;
    for (int unsigned k = 0; k < MAX_N; k++) begin
      if (k < n) begin
        idx = 32'(ptr) + k;
        if (idx >= n) idx = idx - n;
        if (!res.found && req[idx[MAX_IW-1:0]]) begin
          res.found = 1'b1;
          res.idx   = idx[MAX_IW-1:0];
        end
      end
    end
    return res;
  endfunction

  function automatic logic [MAX_IW-1:0] onehot2idx(input logic [MAX_N-1:0] oh);
    logic [MAX_IW-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAX_N; i++) begin
      if (oh[i]) r = r | MAX_IW'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/and_or_mux.sv
// AND-OR select of one of N data words by an at-most-one-hot select vector.
// Latency: combinational.
// Backpressure: none; an all-zero select yields an all-zero word.
//
// Ports:
//   sel_i  in  N        one-hot (or zero) select
//   dat_i  in  N*DW     candidate words, packed [N-1:0][DW-1:0]
//   dat_o  out DW       selected word
module and_or_mux #(
  parameter int unsigned N  = 4,
  parameter int unsigned DW = 16
) (
  input  logic [N-1:0]         sel_i,
  input  logic [N-1:0][DW-1:0] dat_i,
  output logic [DW-1:0]        dat_o
);

  always_comb begin
    dat_o = '0;
    for (int i = 0; i < N; i++) begin
      dat_o = dat_o | (dat_i[i] & {DW{sel_i[i]}});
    end
  end

endmodule

// File: rtl/rr_arb_reg_stage.sv
// Round-robin arbiter over N valid/ready requesters feeding a 1-deep output register.
// Latency: a word accepted in cycle t is on out_* in cycle t+1; 1 word/cycle when out_ready_i=1.
// Backpressure: while the register is full and out_ready_i=0 no grant is issued and state holds.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   req_valid_i/req_data_i  per-requester request and data word
//   req_last_i              last beat of packet (only with ARB_LOCK_EN defined)
//   req_ready_o/grant_o     one-hot accept of the current cycle (identical)
//   out_valid_o/out_data_o/out_src_o/out_ready_i  registered output handshake
// Build option: define ARB_LOCK_EN to keep the grant on one requester until its last beat.
module rr_arb_reg_stage
  import sbuf_pkg::*;
#(
  parameter  int unsigned N  = 4,
  parameter  int unsigned DW = 16,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N-1:0]         req_valid_i,
  input  logic [N-1:0][DW-1:0] req_data_i,
`ifdef ARB_LOCK_EN
  input  logic [N-1:0]         req_last_i,
`endif
  output logic [N-1:0]         req_ready_o,
  output logic [N-1:0]         grant_o,
  output logic                 out_valid_o,
  output logic [DW-1:0]        out_data_o,
  output logic [IW-1:0]        out_src_o,
  input  logic                 out_ready_i
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [IW-1:0] out_src_q, out_src_d;

  logic [N-1:0]  eligible;
  logic [N-1:0]  grant;
  logic          load;
  rr_pick_t      pick;
  logic [IW-1:0] sel_idx;
  logic [IW-1:0] ptr_adv;
  logic [DW-1:0] mux_dat;

`ifdef ARB_LOCK_EN
  lk_state_t     lk_state_q, lk_state_d;
  logic [IW-1:0] lock_idx_q, lock_idx_d;
  logic [N-1:0]  lock_mask;
  logic          sel_last;

  // While locked only the owning requester may be picked; everyone else starves.
  always_comb begin
    lock_mask = '1;
    if (lk_state_q == LK_LOCKED) lock_mask = N'(1) << lock_idx_q;
    eligible = req_valid_i & lock_mask;
  end
`else
  assign eligible = req_valid_i;
`endif

  always_comb begin
    pick = rr_pick(MAX_N'(eligible), MAX_IW'(ptr_q), N);
    // Reset is folded into load so no requester sees an accept during reset cycles.
    load = !rst_i && (!out_valid_q || out_ready_i) && pick.found;
    grant = '0;
    if (load) grant = N'(1) << pick.idx;
    sel_idx = IW'(onehot2idx(MAX_N'(grant)));
    ptr_adv = (sel_idx == IW'(N - 1)) ? '0 : sel_idx + IW'(1);
  end

  assign grant_o     = grant;
  assign req_ready_o = grant;

  and_or_mux #(.N(N), .DW(DW)) u_mux (
    .sel_i (grant),
    .dat_i (req_data_i),
    .dat_o (mux_dat)
  );

`ifdef ARB_LOCK_EN
  assign sel_last = |(req_last_i & grant);

  // The pointer only moves when a packet completes, so a multi-beat packet
  // does not cost its owner its round-robin turn.
  always_comb begin
    lk_state_d = lk_state_q;
    lock_idx_d = lock_idx_q;
    ptr_d      = ptr_q;
    if (load) begin
      if (!sel_last) begin
        lk_state_d = LK_LOCKED;
        lock_idx_d = sel_idx;
      end else begin
        lk_state_d = LK_IDLE;
        ptr_d      = ptr_adv;
      end
    end
  end
`else
  always_comb begin
    ptr_d = ptr_q;
    if (load) ptr_d = ptr_adv;
  end
`endif

  // A load overwrites the register even when it drains in the same cycle.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_dat;
      out_src_d   = sel_idx;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
`ifdef ARB_LOCK_EN
      lk_state_q  <= LK_IDLE;
      lock_idx_q  <= '0;
`endif
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
`ifdef ARB_LOCK_EN
      lk_state_q  <= lk_state_d;
      lock_idx_q  <= lock_idx_d;
`endif
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_src_o   = out_src_q;

  // Requesters must hold valid and data steady until accepted.
  for (genvar gi = 0; gi < N; gi++) begin : g_proto
    a_req_hold: assert property (@(posedge clk_i) disable iff (rst_i)
      (req_valid_i[gi] && !req_ready_o[gi]) |=> (req_valid_i[gi] && $stable(req_data_i[gi])));
  end

  a_grant_onehot: assert property (@(posedge clk_i) $onehot0(grant_o));

endmodule
